if_pc_unit: RTL and testbench
=============================

# if_pc_unit

Program-counter register and next-PC selector for the instruction-fetch stage of the MIPS pipeline. It drives the current PC to the PC incrementer and to instruction memory, and takes the incremented value back. It chooses the next PC from the sequential, branch and jump sources. It also applies stalls, supports debug-unit single-step mode, freezes on HALT, and counts executed fetch cycles.

## Interface
- NB_ADDR, 32, PC and target width
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- NB_CNT, 32, width of fetch-cycle counter

Ports:
- i_clk  in  1  the single clock; all state updates on its rising edge
- i_reset  in  1  synchronous, active-high reset
- i_pc_inc  in  NB_ADDR  incremented PC returned by the incrementer (o_pc + 4)
- i_branch_taken  in  1  branch resolved taken (EX)
- i_branch_target  in  NB_ADDR  branch destination
- i_jump  in  1  jump decoded (ID)
- i_jump_target  in  NB_ADDR  jump destination
- i_stall  in  1  hazard unit hold request
- i_halt  in  1  HALT instruction decoded
- i_step_mode  in  1  debug unit: 1 = advance only on i_step
- i_step  in  1  single-cycle step pulse
- o_pc  out  NB_ADDR  current PC
- o_pc_valid  out  1  o_pc is a fetch to be issued this cycle
- o_halted  out  1  PC frozen by HALT
- o_fetch_count  out  NB_CNT  number of PC advances since reset

## Operation
- State machine with states RUN, STEP_WAIT and HALTED:
  - RUN: the PC may advance every cycle.
  - STEP_WAIT: the PC advances only in cycles with i_step = 1.
  - HALTED: the PC is frozen.
- Transitions:
  - RUN → STEP_WAIT when i_step_mode = 1.
  - STEP_WAIT → RUN when i_step_mode = 0.
  - RUN or STEP_WAIT → HALTED on i_halt = 1.
  - HALTED is left only by reset.
- Advance enable (adv):
  - In RUN: adv = !i_stall, except that a redirect overrides the stall.
  - In STEP_WAIT: adv = i_step, and a redirect only takes effect when i_step = 1.
  - In HALTED: adv = 0.
- Next-PC priority, highest first:
  1. i_reset
  2. HALTED (hold)
  3. i_branch_taken → i_branch_target
  4. i_jump → i_jump_target
  5. i_stall → hold
  6. otherwise i_pc_inc
- Branch beats jump in the same cycle because the branch is the older instruction.
- Alignment: bits [1:0] of every loaded value are forced to 0, so o_pc[1:0] is always 0.
- Wrap-around: i_pc_inc = 32'h0000_0000 after 32'hFFFF_FFFC is loaded as-is; there is no overflow flag.
- i_halt and a redirect in the same cycle: the redirect target is loaded and the state becomes HALTED, so o_pc holds the target.
- o_fetch_count increments by 1 on every cycle in which the PC register loads a new value (adv = 1). It wraps modulo 2^NB_CNT.

## Timing
- Reset values: o_pc = RESET_PC, o_pc_valid = 0, o_halted = 0, o_fetch_count = 0, state = RUN.
- o_pc_valid = 1 from the first cycle after reset is deasserted, in RUN, when i_stall = 0.
- o_pc_valid is 0 while stalled, while in STEP_WAIT without i_step, and while HALTED.
- Next-PC latency: one cycle. A source sampled at edge N appears on o_pc after edge N.
- o_halted rises the cycle after i_halt is sampled.
- o_pc, o_halted and o_fetch_count are registered outputs. o_pc_valid is a combinational decode of state, i_stall and i_step.
- Reset asserted mid-operation, in any state: all outputs return to their reset values at the next edge, overriding every other input.

## Structure
- Shared package if_pkg holds:
  - NB_ADDR and RESET_PC
  - the state encoding (RUN = 2'b00, STEP_WAIT = 2'b01, HALTED = 2'b10)
- One natural sub-module, if_fetch_counter: an NB_CNT-wide counter with synchronous clear and enable.
- The next-PC mux stays inline.

## Test plan
- Reset then free run, with the incrementer in loop: o_pc steps 0x0 → 0x4 → 0x8 → 0xC on consecutive cycles; o_fetch_count = 3 after three advances.
- At o_pc = 0x10, i_stall = 1 for 2 cycles: o_pc holds 0x10 and o_pc_valid = 0 during the stall; the next value is 0x14.
- Same cycle i_branch_taken = 1 with target 0x40, i_jump = 1 with target 0x80, and i_stall = 1: the next o_pc = 0x40.
- i_step_mode = 1 with i_step pulsed on every 3rd cycle: o_pc advances by 4 only after each pulse; o_fetch_count equals the number of pulses.
- i_halt at o_pc = 0x20: o_halted = 1 the next cycle; o_pc stays 0x20 for 10 cycles despite branches; i_reset returns o_pc to 0x0 and o_halted to 0.
- o_pc = 0xFFFF_FFFC with incrementer wrap: the next o_pc = 0x0. A branch target of 0x43 loads as 0x40.

Source files
------------

// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch PC unit.
package if_pkg;

  localparam int          IF_NB_ADDR  = 32;
  localparam logic [31:0] IF_RESET_PC = 32'h0000_0000;

  // Fetch control states
  typedef enum logic [1:0] {
    ST_RUN       = 2'b00,
    ST_STEP_WAIT = 2'b01,
    ST_HALTED    = 2'b10
  } if_state_e;

endpackage

// File: rtl/if_fetch_counter.sv
// Free-running cycle counter with synchronous clear and enable; wraps naturally.
module if_fetch_counter #(
  parameter int NB_CNT = 32
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              en,
  output logic [NB_CNT-1:0] count
);

  // Clear has priority over enable.
  always_ff @(posedge clk) begin
    if (clear)   count <= '0;
    else if (en) count <= count + NB_CNT'(1);
  end

endmodule

// File: rtl/if_pc_unit.sv
// Program counter and next-PC selection for the IF stage: sequential, branch
// and jump sources, stall hold, debug single-step, HALT freeze, fetch counter.
module if_pc_unit
  import if_pkg::*;
#(
  parameter int                 NB_ADDR  = IF_NB_ADDR,
  parameter logic [NB_ADDR-1:0] RESET_PC = NB_ADDR'(IF_RESET_PC),
  parameter int                 NB_CNT   = 32
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_ADDR-1:0] i_pc_inc,
  input  logic               i_branch_taken,
  input  logic [NB_ADDR-1:0] i_branch_target,
  input  logic               i_jump,
  input  logic [NB_ADDR-1:0] i_jump_target,
  input  logic               i_stall,
  input  logic               i_halt,
  input  logic               i_step_mode,
  input  logic               i_step,
  output logic [NB_ADDR-1:0] o_pc,
  output logic               o_pc_valid,
  output logic               o_halted,
  output logic [NB_CNT-1:0]  o_fetch_count
);

  // Word alignment: low two bits of any loaded PC are dropped.
  localparam logic [NB_ADDR-1:0] ALIGN_MASK = {{(NB_ADDR-2){1'b1}}, 2'b00};

  if_state_e          state, state_nxt;
  logic               redirect;
  logic               seq_ok;
  logic               adv;
  logic               valid;
  logic [NB_ADDR-1:0] pc_sel;

  // Branch is the older instruction, so it wins over a same-cycle jump.
  always_comb begin
    redirect = i_branch_taken | i_jump;
    if (i_branch_taken) pc_sel = i_branch_target;
    else if (i_jump)    pc_sel = i_jump_target;
    else                pc_sel = i_pc_inc;
  end

  // Next-state, advance enable and fetch-valid decode.
  always_comb begin
    state_nxt = state;
    adv       = 1'b0;
    valid     = 1'b0;
    // Sequential advance is blocked by a stall and by a HALT being decoded;
    // a redirect still lands even in those cycles.
    seq_ok    = !i_stall && !i_halt;
    case (state)
      ST_RUN: begin
        adv   = redirect | seq_ok;
        valid = !i_stall;
        if (i_halt)           state_nxt = ST_HALTED;
        else if (i_step_mode) state_nxt = ST_STEP_WAIT;
      end
      ST_STEP_WAIT: begin
        adv   = i_step & (redirect | seq_ok);
        valid = i_step & !i_stall;
        if (i_halt)            state_nxt = ST_HALTED;
        else if (!i_step_mode) state_nxt = ST_RUN;
      end
      ST_HALTED: begin
        state_nxt = ST_HALTED;
      end
      default: begin
        state_nxt = ST_RUN;
      end
    endcase
    if (i_reset) begin
      adv   = 1'b0;
      valid = 1'b0;
    end
  end

  // State register; reset returns to RUN from anywhere, including HALTED.
  always_ff @(posedge i_clk) begin
    if (i_reset) state <= ST_RUN;
    else         state <= state_nxt;
  end

  // PC register loads only on advance.
  always_ff @(posedge i_clk) begin
    if (i_reset)  o_pc <= RESET_PC & ALIGN_MASK;
    else if (adv) o_pc <= pc_sel & ALIGN_MASK;
  end

  assign o_pc_valid = valid;
  assign o_halted   = (state == ST_HALTED);

  if_fetch_counter #(.NB_CNT(NB_CNT)) u_cnt (
    .clk   (i_clk),
    .clear (i_reset),
    .en    (adv),
    .count (o_fetch_count)
  );

endmodule

// File: tb/tb_if_pc_unit.sv
// Self-checking bench for if_pc_unit: vector table, directed sequences and a
// randomized run against a behavioural model.
module tb_if_pc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_inc, br_tgt, j_tgt;
  logic        br, j, stall, halt, smode, step;
  logic [31:0] pc, cnt;
  logic        pc_valid, halted;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  if_pc_unit dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_pc_inc       (pc_inc),
    .i_branch_taken (br),
    .i_branch_target(br_tgt),
    .i_jump         (j),
    .i_jump_target  (j_tgt),
    .i_stall        (stall),
    .i_halt         (halt),
    .i_step_mode    (smode),
    .i_step         (step),
    .o_pc           (pc),
    .o_pc_valid     (pc_valid),
    .o_halted       (halted),
    .o_fetch_count  (cnt)
  );

  typedef struct {
    logic        rst;
    logic [31:0] inc;
    logic        br;
    logic [31:0] bt;
    logic        j;
    logic [31:0] jt;
    logic        stall, halt, smode, step;
  } in_t;

  typedef struct {
    in_t         in;
    logic        e_valid;
    logic [31:0] e_pc;
    logic        e_halted;
    logic [31:0] e_cnt;
  } vec_t;

  function automatic in_t mk(logic r, logic [31:0] inc, logic b, logic [31:0] bt,
                             logic jj, logic [31:0] jt, logic s, logic h,
                             logic sm, logic st);
    in_t v;
    v.rst = r; v.inc = inc; v.br = b; v.bt = bt; v.j = jj; v.jt = jt;
    v.stall = s; v.halt = h; v.smode = sm; v.step = st;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(in_t v);
    rst = v.rst; pc_inc = v.inc; br = v.br; br_tgt = v.bt; j = v.j; j_tgt = v.jt;
    stall = v.stall; halt = v.halt; smode = v.smode; step = v.step;
  endtask

  // Behavioural model: PC, halted flag, step-mode flag, advance count.
  logic [31:0] m_pc;
  bit          m_halted, m_stepm;
  logic [31:0] m_cnt;

  function automatic logic m_valid(in_t v);
    if (v.rst || m_halted) return 1'b0;
    if (m_stepm)           return v.step && !v.stall;
    return !v.stall;
  endfunction

  task automatic m_update(in_t v);
    bit go;
    if (v.rst) begin
      m_pc = 32'h0; m_halted = 0; m_stepm = 0; m_cnt = 0;
    end else if (!m_halted) begin
      go = m_stepm ? v.step : 1'b1;
      if (go && (v.br || v.j)) begin
        m_pc  = (v.br ? v.bt : v.jt) & 32'hFFFF_FFFC;
        m_cnt = m_cnt + 1;
      end else if (go && !v.stall && !v.halt) begin
        m_pc  = v.inc & 32'hFFFF_FFFC;
        m_cnt = m_cnt + 1;
      end
      if (v.halt) m_halted = 1;
      else        m_stepm  = v.smode;
    end
  endtask

  // One cycle checked against the model.
  task automatic mcyc(in_t v, string tag);
    @(negedge clk);
    drive(v);
    #1;
    chk({tag, ".valid"}, {31'b0, pc_valid}, {31'b0, m_valid(v)});
    m_update(v);
    @(posedge clk);
    #1;
    chk({tag, ".pc"},     pc,               m_pc);
    chk({tag, ".halted"}, {31'b0, halted},  {31'b0, m_halted});
    chk({tag, ".cnt"},    cnt,              m_cnt);
  endtask

  function automatic in_t seq_in(logic s, logic h, logic sm, logic st);
    return mk(0, m_pc + 4, 0, 0, 0, 0, s, h, sm, st);
  endfunction

  vec_t vt[15];

  initial begin
    in_t v;
    int  pulses;
    bit  rsm;
    drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Vector table: free run, stall, branch/jump/stall collision, wrap, alignment
    vt[0]  = '{mk(1, 32'h0,  0, 0, 0, 0, 0, 0, 0, 0), 0, 32'h0, 0, 0};
    vt[1]  = '{mk(0, 32'h4,  0, 0, 0, 0, 0, 0, 0, 0), 1, 32'h4, 0, 1};
    vt[2]  = '{mk(0, 32'h8,  0, 0, 0, 0, 0, 0, 0, 0), 1, 32'h8, 0, 2};
    vt[3]  = '{mk(0, 32'hC,  0, 0, 0, 0, 0, 0, 0, 0), 1, 32'hC, 0, 3};
    vt[4]  = '{mk(0, 32'h10, 0, 0, 0, 0, 0, 0, 0, 0), 1, 32'h10, 0, 4};
    vt[5]  = '{mk(0, 32'h14, 0, 0, 0, 0, 1, 0, 0, 0), 0, 32'h10, 0, 4};
    vt[6]  = '{mk(0, 32'h14, 0, 0, 0, 0, 1, 0, 0, 0), 0, 32'h10, 0, 4};
    vt[7]  = '{mk(0, 32'h14, 0, 0, 0, 0, 0, 0, 0, 0), 1, 32'h14, 0, 5};
    vt[8]  = '{mk(0, 32'h18, 1, 32'h40, 1, 32'h80, 1, 0, 0, 0), 0, 32'h40, 0, 6};
    vt[9]  = '{mk(0, 32'h44, 0, 0, 1, 32'h80, 0, 0, 0, 0), 1, 32'h80, 0, 7};
    vt[10] = '{mk(0, 32'h84, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0), 1, 32'hFFFF_FFFC, 0, 8};
    vt[11] = '{mk(0, 32'h0,  0, 0, 0, 0, 0, 0, 0, 0), 1, 32'h0, 0, 9};
    vt[12] = '{mk(0, 32'h4,  1, 32'h43, 0, 0, 0, 0, 0, 0), 1, 32'h40, 0, 10};
    vt[13] = '{mk(0, 32'h46, 0, 0, 0, 0, 0, 0, 0, 0), 1, 32'h44, 0, 11};
    vt[14] = '{mk(1, 32'h48, 1, 32'h100, 0, 0, 0, 1, 0, 0), 0, 32'h0, 0, 0};

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      drive(vt[i].in);
      #1;
      chk($sformatf("vec%0d.valid", i), {31'b0, pc_valid}, {31'b0, vt[i].e_valid});
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d.pc", i),     pc,              vt[i].e_pc);
      chk($sformatf("vec%0d.halted", i), {31'b0, halted}, {31'b0, vt[i].e_halted});
      chk($sformatf("vec%0d.cnt", i),    cnt,             vt[i].e_cnt);
    end

    // Single-step: enter step mode while stalled, then step every 3rd cycle
    mcyc(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "st.rst");
    mcyc(seq_in(1, 0, 1, 0), "st.enter");
    pulses = 0;
    for (int i = 1; i <= 12; i++) begin
      if (i % 3 == 0) pulses++;
      mcyc(seq_in(0, 0, 1, (i % 3 == 0)), $sformatf("st%0d", i));
    end
    chk("step.count", cnt, 32'(pulses));
    chk("step.pc",    pc,  32'h10);

    // HALT at 0x20, then branches are ignored for 10 cycles, then reset
    mcyc(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "h.rst");
    for (int i = 0; i < 8; i++) mcyc(seq_in(0, 0, 0, 0), "h.run");
    mcyc(seq_in(0, 1, 0, 0), "h.halt");
    for (int i = 0; i < 10; i++)
      mcyc(mk(0, m_pc + 4, 1, $urandom, i[0], $urandom, 0, 0, 0, 0), "h.frozen");
    chk("halt.pc", pc, 32'h20);
    chk("halt.flag", {31'b0, halted}, 32'h1);
    mcyc(mk(1, 0, 1, 32'h200, 0, 0, 0, 0, 0, 0), "h.reset");
    chk("halt.reset_pc", pc, 32'h0);

    // HALT together with a branch: target loaded, then frozen
    mcyc(mk(0, 32'h4, 1, 32'h100, 0, 0, 0, 1, 0, 0), "hr.both");
    mcyc(seq_in(0, 0, 0, 0), "hr.after");
    chk("halt_redirect.pc", pc, 32'h100);

    // Randomized run against the model
    mcyc(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "r.rst");
    rsm = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0) rsm = !rsm;
      v = mk(($urandom_range(0, 39) == 0),
             ($urandom_range(0, 7) == 0) ? $urandom : m_pc + 4,
             ($urandom_range(0, 7) == 0), $urandom,
             ($urandom_range(0, 7) == 0), $urandom,
             ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 49) == 0),
             rsm, $urandom_range(0, 1) == 1);
      mcyc(v, "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
